// File: rtl/vga_score_counter.sv
// vga_score_counter: packed-BCD score keeper for the snake game.
//
// Point events are queued in a small pending counter and applied one at a time:
// each increment ripples through the BCD digits one digit per cycle, then the new
// score is compared against the high score. The display outputs are snapshots
// taken only on frame_start (or deferred until the ripple finishes), so the
// seven-segment renderers never see a half-carried value or a mid-frame change.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   inc            one-cycle pulse per point earned
//   clear          synchronous game restart (zeroes score, keeps high score)
//   frame_start    one-cycle pulse at start of vertical blanking
//   score_digits   displayed score snapshot, digit 0 (LSD) in [3:0]
//   hiscore_digits displayed high-score snapshot, same packing
//   busy           increment in progress or queued
//   overflow       sticky: increment discarded because score was all 9s
//   drop_err       sticky: inc discarded because the pending counter was full
module vga_score_counter #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned PEND_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inc,
  input  logic                   clear,
  input  logic                   frame_start,
  output logic [4*NDIGITS-1:0]   score_digits,
  output logic [4*NDIGITS-1:0]   hiscore_digits,
  output logic                   busy,
  output logic                   overflow,
  output logic                   drop_err
);

  localparam int unsigned SW = 4 * NDIGITS;
  localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StAdd, StCmp} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     score_q, score_d;
  logic [SW-1:0]     hiscore_q, hiscore_d;
  logic [SW-1:0]     score_disp_q, score_disp_d;
  logic [SW-1:0]     hiscore_disp_q, hiscore_disp_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [DW-1:0]     d_q, d_d;
  logic              snap_req_q, snap_req_d;
  logic              overflow_q, overflow_d;
  logic              drop_err_q, drop_err_d;

  logic              all_nines;
  logic              pend_nz;
  logic              pend_full;
  logic              deq;
  logic              flush;
  logic              inc_acc;
  logic [3:0]        cur_digit;

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  assign pend_nz   = (pending_q != '0);
  assign pend_full = (pending_q == {PEND_W{1'b1}});
  // Start an increment, or discard the whole queue when the score cannot grow.
  assign deq       = (state_q == StIdle) && pend_nz && !all_nines;
  assign flush     = (state_q == StIdle) && pend_nz && all_nines;
  // A same-cycle dequeue frees a slot, so a full queue can still take the inc.
  assign inc_acc   = inc && (!pend_full || deq);
  assign cur_digit = score_q[4*int'(d_q) +: 4];

  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    hiscore_d      = hiscore_q;
    score_disp_d   = score_disp_q;
    hiscore_disp_d = hiscore_disp_q;
    pending_d      = pending_q;
    d_d            = d_q;
    snap_req_d     = snap_req_q;
    overflow_d     = overflow_q;
    drop_err_d     = drop_err_q;

    if (clear) begin
      state_d    = StIdle;
      score_d    = '0;
      pending_d  = '0;
      d_d        = '0;
      snap_req_d = 1'b0;
      overflow_d = 1'b0;
      drop_err_d = 1'b0;
      if (frame_start) begin
        score_disp_d   = '0;
        hiscore_disp_d = hiscore_q;
      end
    end else begin
      if (inc && !inc_acc) drop_err_d = 1'b1;

      if (flush) begin
        pending_d = '0;
      end else if (inc_acc && !deq) begin
        pending_d = pending_q + PEND_W'(1);
      end else if (!inc_acc && deq) begin
        pending_d = pending_q - PEND_W'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (flush) begin
            overflow_d = 1'b1;
          end else if (deq) begin
            d_d     = '0;
            state_d = StAdd;
          end
          if (frame_start) begin
            score_disp_d   = score_q;
            hiscore_disp_d = hiscore_q;
          end
        end
        StAdd: begin
          if (cur_digit == 4'd9) begin
            score_d[4*int'(d_q) +: 4] = 4'd0;
            d_d                       = d_q + DW'(1);
          end else begin
            score_d[4*int'(d_q) +: 4] = cur_digit + 4'd1;
            state_d                   = StCmp;
          end
          // Score is mid-ripple; hold the snapshot until the carry settles.
          if (frame_start) snap_req_d = 1'b1;
        end
        StCmp: begin
          // Packed BCD orders the same as its decimal value.
          if (score_q > hiscore_q) hiscore_d = score_q;
          if (frame_start || snap_req_q) begin
            score_disp_d   = score_q;
            hiscore_disp_d = hiscore_d;
          end
          snap_req_d = 1'b0;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      score_q        <= '0;
      hiscore_q      <= '0;
      score_disp_q   <= '0;
      hiscore_disp_q <= '0;
      pending_q      <= '0;
      d_q            <= '0;
      snap_req_q     <= 1'b0;
      overflow_q     <= 1'b0;
      drop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      hiscore_q      <= hiscore_d;
      score_disp_q   <= score_disp_d;
      hiscore_disp_q <= hiscore_disp_d;
      pending_q      <= pending_d;
      d_q            <= d_d;
      snap_req_q     <= snap_req_d;
      overflow_q     <= overflow_d;
      drop_err_q     <= drop_err_d;
    end
  end

  assign score_digits   = score_disp_q;
  assign hiscore_digits = hiscore_disp_q;
  assign busy           = (state_q != StIdle) || pend_nz;
  assign overflow       = overflow_q;
  assign drop_err       = drop_err_q;

endmodule

// File: tb/tb_vga_score_counter.sv
// Bench for vga_score_counter (NDIGITS=4, PEND_W=2). A behavioural model keeps
// the score as a plain integer, the queue as a count and an increment's duration
// from its trailing-9s count; every cycle the DUT outputs are compared with it.
module tb_vga_score_counter;

  localparam int PMAX = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        inc = 1'b0;
  logic        clear = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] score_digits;
  logic [15:0] hiscore_digits;
  logic        busy;
  logic        overflow;
  logic        drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state.
  int m_sc, m_hi, m_pend, m_phase, m_add_left, m_disp_s, m_disp_h, m_acc;
  bit m_snap, m_ovf, m_drp;

  vga_score_counter #(
    .NDIGITS (4),
    .PEND_W  (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .inc            (inc),
    .clear          (clear),
    .frame_start    (frame_start),
    .score_digits   (score_digits),
    .hiscore_digits (hiscore_digits),
    .busy           (busy),
    .overflow       (overflow),
    .drop_err       (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int trail9(input int v);
    int k;
    int x;
    k = 0;
    x = v;
    while (k < 4 && (x % 10) == 9) begin
      k++;
      x = x / 10;
    end
    return k;
  endfunction

  task automatic model_reset();
    m_sc = 0; m_hi = 0; m_pend = 0; m_phase = 0; m_add_left = 0;
    m_disp_s = 0; m_disp_h = 0; m_acc = 0;
    m_snap = 0; m_ovf = 0; m_drp = 0;
  endtask

  // phase: 0 waiting, 1 rippling (m_add_left digit cycles left), 2 compare cycle.
  task automatic model_step(input bit i_inc, input bit i_clr, input bit i_fs);
    bit deq, flush, acc;
    if (i_clr) begin
      m_sc = 0; m_pend = 0; m_phase = 0; m_snap = 0; m_ovf = 0; m_drp = 0;
      if (i_fs) begin
        m_disp_s = 0;
        m_disp_h = m_hi;
      end
      return;
    end
    deq   = (m_phase == 0) && (m_pend > 0) && (m_sc != 9999);
    flush = (m_phase == 0) && (m_pend > 0) && (m_sc == 9999);
    if (m_phase == 0 && i_fs) begin
      m_disp_s = m_sc;
      m_disp_h = m_hi;
    end
    if (m_phase == 2 && (i_fs || m_snap)) begin
      m_disp_s = m_sc;
      m_disp_h = (m_sc > m_hi) ? m_sc : m_hi;
    end
    if (m_phase == 1 && i_fs) m_snap = 1;
    if (m_phase == 2) m_snap = 0;
    acc = i_inc && (m_pend < PMAX || deq);
    if (acc) m_acc++;
    if (i_inc && !acc) m_drp = 1;
    if (flush) begin
      m_pend = 0;
      m_ovf  = 1;
    end else begin
      m_pend = m_pend + int'(acc) - int'(deq);
    end
    case (m_phase)
      0: if (deq) begin
        m_phase    = 1;
        m_add_left = trail9(m_sc) + 1;
      end
      1: begin
        m_add_left--;
        if (m_add_left == 0) begin
          m_sc++;
          m_phase = 2;
        end
      end
      default: begin
        if (m_sc > m_hi) m_hi = m_sc;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    check_eq("score_digits", score_digits, to_bcd(m_disp_s));
    check_eq("hiscore_digits", hiscore_digits, to_bcd(m_disp_h));
    check_eq("busy", busy, (m_phase != 0) || (m_pend != 0));
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_err", drop_err, m_drp);
  endtask

  task automatic cycle(input bit i_inc, input bit i_clr, input bit i_fs);
    inc = i_inc;
    clear = i_clr;
    frame_start = i_fs;
    @(posedge clk);
    model_step(i_inc, i_clr, i_fs);
    #1;
    inc = 1'b0;
    clear = 1'b0;
    frame_start = 1'b0;
    check_outputs();
  endtask

  // Reset is asserted between edges so the asynchronous clear is visible at once.
  task automatic do_reset();
    reset_n = 1'b0;
    inc = 1'b0;
    clear = 1'b0;
    frame_start = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq("idle_reached", busy, 1'b0);
  endtask

  task automatic pump_to(input int target);
    int guard;
    guard = 0;
    while ((m_sc + m_pend + int'(m_phase == 1)) < target && guard < 60000) begin
      cycle(m_pend < PMAX, 1'b0, 1'b0);
      guard++;
    end
    check_eq("pump_reached", m_sc + m_pend + int'(m_phase == 1), target);
    wait_idle();
  endtask

  initial begin
    int n;
    model_reset();
    #2;

    // Reset state.
    do_reset();

    // Single point: busy for exactly 3 cycles, then shown on frame_start.
    cycle(1'b1, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 10) begin
      n++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    check_eq("single_busy_len", n, 3);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("single_score", score_digits, 16'h0001);
    check_eq("single_hiscore", hiscore_digits, 16'h0001);

    // Clear with simultaneous inc keeps the high score and adds nothing.
    pump_to(57);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    pump_to(42);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("pre_clear_score", score_digits, 16'h0042);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("clear_score", score_digits, 16'h0000);
    check_eq("clear_hiscore", hiscore_digits, 16'h0057);
    check_eq("clear_overflow", overflow, 1'b0);
    check_eq("clear_busy", busy, 1'b0);

    // Carry ripple with a frame_start deferred across the ripple.
    do_reset();
    pump_to(199);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("ripple_pre", score_digits, 16'h0199);
    n = 0;
    cycle(1'b1, 1'b0, 1'b0); n += int'(busy);  // queued
    cycle(1'b0, 1'b0, 1'b0); n += int'(busy);  // idle -> first digit
    cycle(1'b0, 1'b0, 1'b0); n += int'(busy);  // first digit
    cycle(1'b0, 1'b0, 1'b1); n += int'(busy);  // second digit, frame_start
    check_eq("ripple_hold", score_digits, 16'h0199);
    cycle(1'b0, 1'b0, 1'b0); n += int'(busy);  // third digit -> compare
    check_eq("ripple_defer", score_digits, 16'h0199);
    cycle(1'b0, 1'b0, 1'b0);                   // compare: snapshot lands
    check_eq("ripple_score", score_digits, 16'h0200);
    check_eq("ripple_hiscore", hiscore_digits, 16'h0200);
    check_eq("ripple_busy_len", n, 5);
    check_eq("ripple_done", busy, 1'b0);

    // Queue overflow: 12 back-to-back points into a 3-deep queue.
    do_reset();
    repeat (12) cycle(1'b1, 1'b0, 1'b0);
    wait_idle();
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("q_drop_err", drop_err, 1'b1);
    check_eq("q_score", score_digits, to_bcd(m_acc));
    check_eq("q_lt12", score_digits < 16'h0012, 1'b1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0);
    end
    wait_idle();

    // Saturation at 9999.
    do_reset();
    pump_to(9999);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("sat_pre", score_digits, 16'h9999);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("sat_busy", busy, 1'b0);
    check_eq("sat_overflow", overflow, 1'b1);
    check_eq("sat_score", score_digits, 16'h9999);

    // Reset in the middle of an increment.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("mid_busy_pre", busy, 1'b1);
    do_reset();
    check_eq("mid_busy_post", busy, 1'b0);
    check_eq("mid_score_post", score_digits, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
